// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit. It processes one SLICE-bit slice per clock and
// returns the WIDTH-bit result over a valid/ready handshake.
module serial_logic_unit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8,
   parameter int CNTW  = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_result,
   output logic             busy,
   output logic [CNTW-1:0]  op_count
);

   // state | meaning
   // IDLE  | waiting for a request, in_ready high
   // RUN   | one slice of the result written per clock
   // HOLD  | result presented, waiting for out_ready
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // WIDTH must be a whole multiple of SLICE
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int BW     = $clog2(WIDTH) + 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_result;
   logic [CNTW-1:0]  r_count;

   logic [BW-1:0]    w_base;
   logic [SLICE-1:0] w_a_slice;
   logic [SLICE-1:0] w_b_slice;
   logic [SLICE-1:0] w_slice;

   assign w_base    = BW'(r_idx) * BW'(SLICE);
   assign w_a_slice = r_a[w_base +: SLICE];
   assign w_b_slice = r_b[w_base +: SLICE];

   always_comb begin
      w_slice = '0;
      case (r_op)
         2'b00:   w_slice = w_a_slice & w_b_slice;
         2'b01:   w_slice = w_a_slice | w_b_slice;
         2'b10:   w_slice = w_a_slice ^ w_b_slice;
         default: w_slice = ~w_a_slice;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 2'b00;
         r_idx    <= '0;
         r_result <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= data_a;
                  r_b     <= data_b;
                  r_op    <= op;
                  r_idx   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_result[w_base +: SLICE] <= w_slice;
               r_idx <= r_idx + IDXW'(1);
               if (r_idx == IDX_LAST) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_count <= r_count + CNTW'(1);
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Handshake flags depend on the state register only, never on inputs.
   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_HOLD);
   assign busy        = (r_state == ST_RUN) || (r_state == ST_HOLD);
   assign data_result = r_result;
   assign op_count    = r_count;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on each handoff.
module tb_serial_logic_unit;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 8;
   localparam int CNTW   = 16;
   localparam int NSLICE = WIDTH / SLICE;

   logic             clock;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_result;
   logic             busy;
   logic [CNTW-1:0]  op_count;

   typedef struct {
      logic [WIDTH-1:0] res;
      int               acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic prev_valid = 1'b0;

   serial_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE), .CNTW(CNTW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .data_a      (data_a),
      .data_b      (data_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .data_result (data_result),
      .busy        (busy),
      .op_count    (op_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: sampled 1 time unit after the falling edge, clear of input changes
   always @(negedge clock) begin
      #1;
      if (!reset_n) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid got result %h with empty scoreboard", data_result);
            end else begin
               chk("latency", 32'(cyc - q[0].acc), 32'(NSLICE));
            end
         end
         if (out_valid && q.size() != 0) begin
            chk("result", data_result, q[0].res);
            if (out_ready) void'(q.pop_front());
         end
         prev_valid = out_valid;
      end
   end

   function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // called at a falling edge; returns at the falling edge after the accepting edge
   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, output int acc_edge);
      int n = 0;
      in_valid = 1'b1;
      op       = o;
      data_a   = a;
      data_b   = b;
      acc_edge = -1;
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got in_ready 0 expected 1");
      end else begin
         chk("model_vs_table", model(o, a, b), exp_res);
         acc_edge = cyc + 1;
         q.push_back('{res: exp_res, acc: acc_edge});
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic drain(input logic [CNTW-1:0] exp_cnt);
      int n = 0;
      while ((q.size() != 0 || out_valid || busy) && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", q.size());
      end
      chk("op_count", 32'(op_count), 32'(exp_cnt));
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      q.delete();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int e1, e2, e3, dummy, n;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      data_a    = '0;
      data_b    = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", data_result, 32'h0);
      chk("rst_count", 32'(op_count), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // 1: OR with latency check in the monitor
      issue(2'b01, 32'h0000FF00, 32'h00000000, 32'h0000FF00, dummy);
      drain(16'd1);

      // 2: remaining ops
      issue(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, dummy);
      issue(2'b10, 32'h11111111, 32'hFFFFFFFF, 32'hEEEEEEEE, dummy);
      issue(2'b11, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, dummy);
      drain(16'd4);

      // 3: back-pressure while a new request waits
      out_ready = 1'b0;
      issue(2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, dummy);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         op       = 2'(i);
         data_a   = 32'h1000_0000 * i;
         data_b   = 32'h0000_1111 * i;
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_result", data_result, 32'hAAAAAAAA);
         chk("hold_count", 32'(op_count), 32'd4);
         @(negedge clock);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(16'd5);

      // 4: operands changing during RUN must not matter
      issue(2'b00, 32'h12345678, 32'hF0F0F0F0, 32'h10305070, dummy);
      for (int i = 0; i < NSLICE; i++) begin
         data_a = ~data_a + 32'(i);
         data_b = 32'h0;
         op     = 2'(i + 1);
         @(negedge clock);
      end
      drain(16'd6);

      // 5: asynchronous reset mid-RUN
      issue(2'b01, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, dummy);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      q.delete();
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd1);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_count", 32'(op_count), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      issue(2'b01, 32'h0000FF00, 32'h00FF0000, 32'h00FFFF00, dummy);
      drain(16'd1);

      // 6: back-to-back with in_valid and out_ready held high
      pulse_reset();
      issue(2'b10, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, e1);
      issue(2'b00, 32'hDEADBEEF, 32'hFFFF0000, 32'hDEAD0000, e2);
      issue(2'b11, 32'h5A5A5A5A, 32'h00000000, 32'hA5A5A5A5, e3);
      chk("spacing_1_2", 32'(e2 - e1), 32'(NSLICE + 2));
      chk("spacing_2_3", 32'(e3 - e2), 32'(NSLICE + 2));
      drain(16'd3);

      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
